axis_gain_ramp: RTL and testbench

Parametrised successor to the single-switch volume stage in the audio path: an AXI-Stream gain block between `axis_i2s2` RX and TX. It applies a multi-bit gain with saturation to interleaved multi-channel frames, and updates gain only on frame boundaries so every channel of a frame shares one gain. It slews gain one LSB per frame to avoid zipper noise, and flags framing errors on `last`.

---
 rtl/axis_gain_ramp.sv | 113 +++++++++++
 tb/tb_axis_gain_ramp.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_gain_ramp.sv
// AXI-Stream gain stage: per-frame gain update, 2-stage multiply/saturate pipeline, framing check.
// Define AXIS_GAIN_RAMP_EN to slew gain one LSB per frame from 0; otherwise gain loads the target directly.
module axis_gain_ramp #(
    parameter int DATA_WIDTH = 24,
    parameter int GAIN_WIDTH = 8,
    parameter int CHANNELS   = 2
) (
    input  logic                  axis_clk,
    input  logic                  axis_resetn,
    input  logic [GAIN_WIDTH-1:0] gain,
    input  logic                  mute,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic                  s_axis_last,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic                  m_axis_last,
    output logic [GAIN_WIDTH-1:0] gain_cur,
    output logic                  frame_err
);
    localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(CHANNELS - 1);

    logic                  adv, accept, at_end, boundary;
    logic [GAIN_WIDTH-1:0] tgt;
    logic [CW-1:0]         chan_idx_q, chan_idx_d;
    logic [GAIN_WIDTH-1:0] gain_cur_q, gain_cur_d;
    logic                  frame_err_q, frame_err_d;
    logic                  s1_vld_q, s1_last_q;
    logic signed [PW-1:0]  s1_prod_q, prod_d, shifted;
    logic [PW-DATA_WIDTH:0] hi;
    logic [DATA_WIDTH-1:0] sat_d, m_data_q;
    logic                  m_valid_q, m_last_q;

    always_comb begin
        tgt         = mute ? '0 : gain;
        adv         = !m_valid_q || m_axis_ready;
        accept      = s_axis_valid && adv;
        at_end      = (chan_idx_q == LAST_IDX);
        boundary    = accept && s_axis_last;
        chan_idx_d  = chan_idx_q;
        frame_err_d = frame_err_q;
        gain_cur_d  = gain_cur_q;
        if (accept) begin
            if (s_axis_last != at_end) frame_err_d = 1'b1;
            // An early last resyncs the frame; a missing last just wraps.
            chan_idx_d = (s_axis_last || at_end) ? '0 : chan_idx_q + CW'(1);
        end
        if (boundary) begin
`ifdef AXIS_GAIN_RAMP_EN
            if (gain_cur_q < tgt)      gain_cur_d = gain_cur_q + GAIN_WIDTH'(1);
            else if (gain_cur_q > tgt) gain_cur_d = gain_cur_q - GAIN_WIDTH'(1);
`else
            gain_cur_d = tgt;
`endif
        end
    end

    always_comb begin
        prod_d  = $signed({{(GAIN_WIDTH+1){s_axis_data[DATA_WIDTH-1]}}, s_axis_data})
                * $signed({{DATA_WIDTH{1'b0}}, 1'b0, gain_cur_q});
        shifted = s1_prod_q >>> (GAIN_WIDTH - 1);
        hi      = shifted[PW-1:DATA_WIDTH-1];
        // In range iff every bit above the output sign bit matches it.
        if (&hi || ~|hi)     sat_d = shifted[DATA_WIDTH-1:0];
        else if (shifted[PW-1]) sat_d = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else                 sat_d = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end

    always_ff @(posedge axis_clk) begin
        if (!axis_resetn) begin
            chan_idx_q  <= '0;
            frame_err_q <= 1'b0;
`ifdef AXIS_GAIN_RAMP_EN
            gain_cur_q  <= '0;
`else
            gain_cur_q  <= tgt;
`endif
            s1_vld_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_prod_q   <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
        end else begin
            chan_idx_q  <= chan_idx_d;
            frame_err_q <= frame_err_d;
            gain_cur_q  <= gain_cur_d;
            if (adv) begin
                s1_vld_q  <= accept;
                if (accept) begin
                    s1_prod_q <= prod_d;
                    s1_last_q <= s_axis_last;
                end
                m_valid_q <= s1_vld_q;
                if (s1_vld_q) begin
                    m_data_q <= sat_d;
                    m_last_q <= s1_last_q;
                end
            end
        end
    end

    assign s_axis_ready = adv;
    assign m_axis_data  = m_data_q;
    assign m_axis_valid = m_valid_q;
    assign m_axis_last  = m_last_q;
    assign gain_cur     = gain_cur_q;
    assign frame_err    = frame_err_q;
endmodule

// File: tb/tb_axis_gain_ramp.sv
// Bench for axis_gain_ramp: constant vectors, hand sequences, and a randomized
// backpressure run scored against an arithmetic reference model.
module tb_axis_gain_ramp;
    localparam int DW = 24;
    localparam int GW = 8;
    localparam int CH = 2;

    logic          axis_clk = 1'b0;
    logic          axis_resetn = 1'b0;
    logic [GW-1:0] gain = 8'd128;
    logic          mute = 1'b0;
    logic [DW-1:0] s_axis_data = '0;
    logic          s_axis_valid = 1'b0;
    logic          s_axis_ready;
    logic          s_axis_last = 1'b0;
    logic [DW-1:0] m_axis_data;
    logic          m_axis_valid;
    logic          m_axis_ready = 1'b1;
    logic          m_axis_last;
    logic [GW-1:0] gain_cur;
    logic          frame_err;

    axis_gain_ramp #(.DATA_WIDTH(DW), .GAIN_WIDTH(GW), .CHANNELS(CH)) dut (
        .axis_clk(axis_clk), .axis_resetn(axis_resetn), .gain(gain), .mute(mute),
        .s_axis_data(s_axis_data), .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready),
        .s_axis_last(s_axis_last), .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid),
        .m_axis_ready(m_axis_ready), .m_axis_last(m_axis_last), .gain_cur(gain_cur),
        .frame_err(frame_err)
    );

    always #5 axis_clk = ~axis_clk;

    typedef struct { logic [DW-1:0] d; logic l; } beat_t;
    typedef struct { logic [GW-1:0] g; logic [DW-1:0] din; logic [DW-1:0] dout; } vec_t;

    int    n_cmp = 0;
    int    n_fail = 0;
    beat_t exp_q[$];
    int    mg;      // model gain currently applied
    int    mpos;    // model channel position
    bit    merr;
    bit    last_acc;
    int    n_acc;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    function automatic logic [DW-1:0] ref_out(logic [DW-1:0] d, int g);
        longint smax = (longint'(1) << (DW - 1)) - 1;
        longint smin = -(longint'(1) << (DW - 1));
        longint p = longint'($signed(d)) * longint'(g);
        p = p >>> (GW - 1);
        if (p > smax) p = smax;
        if (p < smin) p = smin;
        return p[DW-1:0];
    endfunction

    // One clock: checks handshake/outputs before the edge, advances the model, checks state after.
    task automatic cycle();
        bit            acc, ofire, stall;
        logic [DW-1:0] snap_d;
        logic          snap_l;
        int            tgt;
        beat_t         b;
        #2;
        chk("s_ready", s_axis_ready, !m_axis_valid || m_axis_ready);
        acc    = s_axis_valid && s_axis_ready && axis_resetn;
        ofire  = m_axis_valid && m_axis_ready && axis_resetn;
        stall  = m_axis_valid && !m_axis_ready && axis_resetn;
        snap_d = m_axis_data;
        snap_l = m_axis_last;
        tgt    = mute ? 0 : int'(gain);
        if (ofire) begin
            if (exp_q.size() == 0) chk("spurious_out", 1, 0);
            else begin
                b = exp_q.pop_front();
                chk("out_data", m_axis_data, b.d);
                chk("out_last", m_axis_last, b.l);
            end
        end
        @(posedge axis_clk);
        last_acc = acc;
        if (!axis_resetn) begin
            exp_q.delete();
            mpos = 0;
            merr = 0;
`ifdef AXIS_GAIN_RAMP_EN
            mg = 0;
`else
            mg = tgt;
`endif
        end else if (acc) begin
            n_acc++;
            b.d = ref_out(s_axis_data, mg);
            b.l = s_axis_last;
            exp_q.push_back(b);
            if (s_axis_last != (mpos == CH - 1)) merr = 1;
            if (s_axis_last) begin
                mpos = 0;
`ifdef AXIS_GAIN_RAMP_EN
                if (mg < tgt) mg++;
                else if (mg > tgt) mg--;
`else
                mg = tgt;
`endif
            end else begin
                mpos = (mpos == CH - 1) ? 0 : mpos + 1;
            end
        end
        #1;
        chk("gain_cur", gain_cur, mg);
        chk("frame_err", frame_err, merr);
        if (stall) begin
            chk("stall_valid", m_axis_valid, 1);
            chk("stall_data", m_axis_data, snap_d);
            chk("stall_last", m_axis_last, snap_l);
        end
    endtask

    task automatic do_reset();
        axis_resetn  = 1'b0;
        s_axis_valid = 1'b0;
        cycle();
        axis_resetn  = 1'b1;
        chk("rst_valid", m_axis_valid, 0);
        chk("rst_data", m_axis_data, 0);
        chk("rst_last", m_axis_last, 0);
        chk("rst_err", frame_err, 0);
`ifdef AXIS_GAIN_RAMP_EN
        chk("rst_gain", gain_cur, 0);
`else
        chk("rst_gain", gain_cur, gain);
`endif
    endtask

    task automatic send(logic [DW-1:0] d, logic l);
        s_axis_valid = 1'b1;
        s_axis_data  = d;
        s_axis_last  = l;
        cycle();
        s_axis_valid = 1'b0;
    endtask

    initial begin
        vec_t tbl[12];
        int   cyc;
        tbl[0]  = '{8'd128, 24'h100000, 24'h100000};
        tbl[1]  = '{8'd128, 24'hF00000, 24'hF00000};
        tbl[2]  = '{8'd255, 24'h7FFFFF, 24'h7FFFFF};
        tbl[3]  = '{8'd255, 24'h800000, 24'h800000};
        tbl[4]  = '{8'd255, 24'h000001, 24'h000001};
        tbl[5]  = '{8'd64,  24'hFFFFFF, 24'hFFFFFF};
        tbl[6]  = '{8'd0,   24'h123456, 24'h000000};
        tbl[7]  = '{8'd1,   24'h000100, 24'h000002};
        tbl[8]  = '{8'd128, 24'h7FFFFF, 24'h7FFFFF};
        tbl[9]  = '{8'd192, 24'h600000, 24'h7FFFFF};
        tbl[10] = '{8'd192, 24'hA00000, 24'h800000};
        tbl[11] = '{8'd3,   24'hFFFFFF, 24'hFFFFFF};
        mg = 0; mpos = 0; merr = 0; n_acc = 0;

        gain = 8'd128;
        do_reset();
`ifndef AXIS_GAIN_RAMP_EN
        // Constant vectors: one beat each after reset, checking latency and value.
        foreach (tbl[i]) begin
            gain = tbl[i].g;
            do_reset();
            s_axis_valid = 1'b1;
            s_axis_data  = tbl[i].din;
            s_axis_last  = 1'b0;
            cycle();
            s_axis_valid = 1'b0;
            chk($sformatf("vec%0d_lat", i), m_axis_valid, 0);
            cycle();
            chk($sformatf("vec%0d_valid", i), m_axis_valid, 1);
            chk($sformatf("vec%0d_data", i), m_axis_data, tbl[i].dout);
        end

        // Unity stereo frame, back to back.
        gain = 8'd128;
        do_reset();
        s_axis_valid = 1'b1; s_axis_data = 24'h100000; s_axis_last = 1'b0;
        cycle();
        chk("uni_l_lat", m_axis_valid, 0);
        s_axis_data = 24'hF00000; s_axis_last = 1'b1;
        cycle();
        s_axis_valid = 1'b0;
        chk("uni_l_valid", m_axis_valid, 1);
        chk("uni_l_data", m_axis_data, 24'h100000);
        chk("uni_l_last", m_axis_last, 0);
        cycle();
        chk("uni_r_data", m_axis_data, 24'hF00000);
        chk("uni_r_last", m_axis_last, 1);
        cycle();
        chk("uni_idle", m_axis_valid, 0);
        chk("uni_err", frame_err, 0);
`else
        // Ramp up by one per frame, hold at target, then fade out under mute.
        gain = 8'd128;
        do_reset();
        for (int k = 1; k <= 130; k++) begin
            send(24'h001000, 1'b0);
            send(24'h001000, 1'b1);
            chk("ramp_up", gain_cur, (k < 128) ? k : 128);
        end
        mute = 1'b1;
        for (int k = 1; k <= 130; k++) begin
            send(24'h001000, 1'b0);
            send(24'h001000, 1'b1);
            chk("ramp_down", gain_cur, (k < 128) ? 128 - k : 0);
        end
        mute = 1'b0;
        repeat (3) cycle();
`endif

        // Early last on beat 0: sticky error through later clean frames.
        do_reset();
        send(24'h000010, 1'b1);
        chk("ferr_early", frame_err, 1);
        for (int k = 0; k < 3; k++) begin
            send(24'h000020, 1'b0);
            send(24'h000030, 1'b1);
        end
        chk("ferr_sticky", frame_err, 1);
        repeat (3) cycle();
        // Missing last on the final channel.
        do_reset();
        send(24'h000040, 1'b0);
        chk("ferr_none", frame_err, 0);
        send(24'h000050, 1'b0);
        chk("ferr_missing", frame_err, 1);
        repeat (3) cycle();

        // Reset with both stages full: nothing stale may come out.
        gain = 8'd128;
        do_reset();
        s_axis_valid = 1'b1; s_axis_last = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_axis_data = DW'(k + 1);
            s_axis_last = (mpos == CH - 1);
            cycle();
        end
        axis_resetn = 1'b0;
        cycle();
        axis_resetn  = 1'b1;
        s_axis_valid = 1'b0;
        chk("mid_rst_valid", m_axis_valid, 0);
`ifdef AXIS_GAIN_RAMP_EN
        chk("mid_rst_gain", gain_cur, 0);
`else
        chk("mid_rst_gain", gain_cur, 128);
`endif
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("mid_rst_quiet", m_axis_valid, 0);
        end

        // Randomized stream under 50% backpressure with gain/mute churn.
        do_reset();
        n_acc = 0;
        cyc = 0;
        while (n_acc < 1000 && cyc < 10000) begin
            m_axis_ready = $urandom_range(0, 1) == 1;
            s_axis_valid = $urandom_range(0, 9) < 8;
            s_axis_data  = DW'($urandom);
            s_axis_last  = (mpos == CH - 1) ^ ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 19) == 0) gain = GW'($urandom_range(0, 255));
            if ($urandom_range(0, 49) == 0) mute = ~mute;
            cycle();
            cyc++;
        end
        chk("rand_done", n_acc >= 1000, 1);
        s_axis_valid = 1'b0;
        m_axis_ready = 1'b1;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) cycle();
        chk("drain_empty", exp_q.size(), 0);
        cycle();
        chk("drain_idle", m_axis_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
